// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO types and sizing helpers.
package fifo_pkg;
   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;
   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: storage array with one synchronous write port and one asynchronous read port.
module fifo_ram_2p #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/empty thresholds,
// fill level, optional first-word-fall-through and sticky overflow/underflow flags.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  write,
   input  logic                  read,
   input  logic [ADDR_WIDTH:0]   alf_thresh,
   input  logic [ADDR_WIDTH:0]   ale_thresh,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  ale,
   output logic                  alf,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_acc, wr_acc;
   fifo_err_t             err;
   assign empty     = count == '0;
   assign full      = count == DEPTH_C;
   assign ale       = count <= ale_thresh;
   assign alf       = count >= alf_thresh;
   assign rd_acc    = read & ~empty;
   // a write into a full FIFO is accepted only when a pop frees a slot in the same cycle
   assign wr_acc    = write & (~full | rd_acc);
   assign overflow  = err.overflow;
   assign underflow = err.underflow;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= '0;
      end else begin
         wr_ptr        <= wr_ptr + ADDR_WIDTH'(wr_acc);
         rd_ptr        <= rd_ptr + ADDR_WIDTH'(rd_acc);
         count         <= count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
         err.overflow  <= (write & ~wr_acc) | (err.overflow & ~clr_err);
         err.underflow <= (read & ~rd_acc) | (err.underflow & ~clr_err);
      end
   end
   fifo_ram_2p #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );
   generate
      if (FWFT) begin : g_fwft
         assign dout       = rd_data;
         assign dout_valid = ~empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_r;
         logic                  valid_r;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               dout_r  <= '0;
               valid_r <= 1'b0;
            end else begin
               dout_r  <= rd_acc ? rd_data : dout_r;
               valid_r <= rd_acc;
            end
         end
         assign dout       = dout_r;
         assign dout_valid = valid_r;
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed vectors against a registered-read and an FWFT instance.
module tb_sync_fifo_prog;
   logic       clk = 0, reset_n = 0;
   logic [4:0] alf_thresh = 5'd14, ale_thresh = 5'd2;
   logic [7:0] din0 = 0, din1 = 0;
   logic       w0 = 0, r0 = 0, c0 = 0, w1 = 0, r1 = 0, c1 = 0;
   logic [7:0] dout0, dout1;
   logic [4:0] cnt0, cnt1;
   logic       dv0, em0, fu0, ale0, alf0, ov0, un0;
   logic       dv1, em1, fu1, ale1, alf1, ov1, un1;
   int         n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u0 (
      .clk(clk), .reset_n(reset_n), .din(din0), .write(w0), .read(r0),
      .alf_thresh(alf_thresh), .ale_thresh(ale_thresh), .clr_err(c0),
      .dout(dout0), .dout_valid(dv0), .count(cnt0), .empty(em0), .full(fu0),
      .ale(ale0), .alf(alf0), .overflow(ov0), .underflow(un0));

   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u1 (
      .clk(clk), .reset_n(reset_n), .din(din1), .write(w1), .read(r1),
      .alf_thresh(alf_thresh), .ale_thresh(ale_thresh), .clr_err(c1),
      .dout(dout1), .dout_valid(dv1), .count(cnt1), .empty(em1), .full(fu1),
      .ale(ale1), .alf(alf1), .overflow(ov1), .underflow(un1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_count", 32'(cnt0), 0);
      check("rst_empty", 32'(em0), 1);
      check("rst_full", 32'(fu0), 0);
      check("rst_ale", 32'(ale0), 1);
      check("rst_alf", 32'(alf0), 0);
      check("rst_dout", 32'(dout0), 0);
      check("rst_valid", 32'(dv0), 0);
      @(negedge clk) reset_n = 1;
      step();
      check("idle_count", 32'(cnt0), 0);

      // fill with 0x00..0x0F
      w0 = 1;
      for (int i = 0; i < 16; i++) begin
         din0 = 8'(i);
         step();
         check("fill_alf", 32'(alf0), 32'(i + 1 >= 14));
         check("fill_ale", 32'(ale0), 32'(i + 1 <= 2));
         check("fill_full", 32'(fu0), 32'(i == 15));
      end
      check("fill_count", 32'(cnt0), 16);
      din0 = 8'hEE;
      step();
      w0 = 0;
      check("ovf_flag", 32'(ov0), 1);
      check("ovf_count", 32'(cnt0), 16);
      check("ovf_valid", 32'(dv0), 0);
      c0 = 1;
      step();
      c0 = 0;
      check("ovf_clr", 32'(ov0), 0);

      // simultaneous read/write while full
      w0 = 1; r0 = 1; din0 = 8'hAA;
      step();
      w0 = 0;
      check("rw_full_count", 32'(cnt0), 16);
      check("rw_full_dout", 32'(dout0), 8'h00);
      check("rw_full_valid", 32'(dv0), 1);
      check("rw_full_ovf", 32'(ov0), 0);
      for (int i = 1; i <= 16; i++) begin
         step();
         check("drain_dout", 32'(dout0), i == 16 ? 32'hAA : 32'(i));
         check("drain_valid", 32'(dv0), 1);
      end
      r0 = 0;
      step();
      check("drain_valid_off", 32'(dv0), 0);
      check("drain_empty", 32'(em0), 1);
      check("drain_dout_hold", 32'(dout0), 8'hAA);
      check("drain_unf", 32'(un0), 0);

      // empty: read and write together
      w0 = 1; r0 = 1; din0 = 8'h77;
      step();
      w0 = 0; r0 = 0;
      check("e_rw_count", 32'(cnt0), 1);
      check("e_rw_unf", 32'(un0), 1);
      check("e_rw_dout", 32'(dout0), 8'hAA);
      check("e_rw_valid", 32'(dv0), 0);
      c0 = 1;
      step();
      c0 = 0;
      check("clr_unf", 32'(un0), 0);
      check("clr_ovf", 32'(ov0), 0);
      r0 = 1;
      step();
      check("pop77_dout", 32'(dout0), 8'h77);
      check("pop77_empty", 32'(em0), 1);
      c0 = 1;
      step();
      r0 = 0;
      check("clr_vs_unf", 32'(un0), 1);
      step();
      c0 = 0;
      check("clr_after", 32'(un0), 0);

      // mid-burst reset: pointers land at wr=9, rd=2 with 7 entries
      w0 = 1;
      for (int i = 0; i < 7; i++) begin
         din0 = 8'hC0 + 8'(i);
         step();
      end
      w0 = 0;
      check("burst_count", 32'(cnt0), 7);
      #2 reset_n = 0;
      #1;
      check("async_count", 32'(cnt0), 0);
      check("async_empty", 32'(em0), 1);
      check("async_dout", 32'(dout0), 0);
      @(negedge clk) reset_n = 1;
      w0 = 1; din0 = 8'h33;
      step();
      w0 = 0; r0 = 1;
      step();
      r0 = 0;
      check("post_rst_dout", 32'(dout0), 8'h33);
      check("post_rst_empty", 32'(em0), 1);

      // FWFT instance
      check("fw_empty", 32'(em1), 1);
      check("fw_valid0", 32'(dv1), 0);
      w1 = 1; din1 = 8'h55;
      step();
      w1 = 0;
      check("fw_dout", 32'(dout1), 8'h55);
      check("fw_valid", 32'(dv1), 1);
      step();
      check("fw_hold", 32'(dout1), 8'h55);
      r1 = 1;
      step();
      r1 = 0;
      check("fw_pop_empty", 32'(em1), 1);
      check("fw_pop_valid", 32'(dv1), 0);
      w1 = 1; din1 = 8'h11;
      step();
      din1 = 8'h22;
      step();
      w1 = 0;
      check("fw_head", 32'(dout1), 8'h11);
      r1 = 1;
      step();
      r1 = 0;
      check("fw_next", 32'(dout1), 8'h22);
      check("fw_next_valid", 32'(dv1), 1);
      check("fw_count", 32'(cnt1), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
